// File: rtl/sram_stream_writer.sv
// Loads SRAM port 0 from a valid/ready stream and optionally verifies by read-back sum.
// Writes land one cycle after acceptance; verify takes length+RD_LAT cycles; in_ready is high for the whole WRITE state.
module sram_stream_writer #(
   parameter int NUM_WMASKS = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  verify_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [NUM_WMASKS-1:0] in_mask,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0,
   output logic                  busy,
   output logic                  done,
   output logic                  match
);

   typedef enum logic [1:0] {IDLE, WRITE, VERIFY} state_t;

   localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic                  verify_q;
   logic [ADDR_WIDTH:0]   wr_cnt, rd_issue_cnt, rd_ret_cnt;
   logic [DATA_WIDTH-1:0] wr_sum, rd_sum, rd_sum_nxt;
   logic [RD_LAT-1:0]     rd_vld_sr;
   logic                  job_start, beat, last_beat, issue, ret, last_ret;

   assign in_ready   = (state == WRITE);
   assign busy       = (state != IDLE);
   assign rd_sum_nxt = rd_sum + dout0;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      job_start = 1'b0;
      beat      = 1'b0;
      last_beat = 1'b0;
      issue     = 1'b0;
      ret       = 1'b0;
      last_ret  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               job_start = 1'b1;
               if (length != '0) state_nxt = WRITE;
            end
         end
         WRITE: begin
            beat      = in_valid;
            last_beat = in_valid && (wr_cnt == len_q - CNT_ONE);
            if (last_beat) state_nxt = verify_q ? VERIFY : IDLE;
         end
         VERIFY: begin
            issue    = (rd_issue_cnt != len_q);
            ret      = rd_vld_sr[RD_LAT-1];
            last_ret = ret && (rd_ret_cnt == len_q - CNT_ONE);
            if (last_ret) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csb0         <= 1'b1;
         web0         <= 1'b1;
         wmask0       <= '0;
         addr0        <= '0;
         din0         <= '0;
         done         <= 1'b0;
         match        <= 1'b0;
         base_q       <= '0;
         len_q        <= '0;
         verify_q     <= 1'b0;
         wr_cnt       <= '0;
         rd_issue_cnt <= '0;
         rd_ret_cnt   <= '0;
         wr_sum       <= '0;
         rd_sum       <= '0;
         rd_vld_sr    <= '0;
      end else begin
         csb0 <= 1'b1;
         web0 <= 1'b1;

         if (job_start) begin
            base_q       <= base_addr;
            len_q        <= length;
            verify_q     <= verify_en;
            done         <= (length == '0);
            match        <= (length == '0);
            wr_cnt       <= '0;
            rd_issue_cnt <= '0;
            rd_ret_cnt   <= '0;
            wr_sum       <= '0;
            rd_sum       <= '0;
         end

         if (beat) begin
            csb0   <= 1'b0;
            web0   <= 1'b0;
            addr0  <= base_q + wr_cnt[ADDR_WIDTH-1:0];
            din0   <= in_data;
            wmask0 <= verify_q ? {NUM_WMASKS{1'b1}} : in_mask;
            wr_sum <= wr_sum + in_data;
            wr_cnt <= wr_cnt + CNT_ONE;
            if (last_beat && !verify_q) begin
               done  <= 1'b1;
               match <= 1'b1;
            end
         end

         if (issue) begin
            csb0         <= 1'b0;
            web0         <= 1'b1;
            wmask0       <= '0;
            addr0        <= base_q + rd_issue_cnt[ADDR_WIDTH-1:0];
            rd_issue_cnt <= rd_issue_cnt + CNT_ONE;
         end

         // Tag travels alongside the read so the matching dout0 is captured RD_LAT edges later.
         rd_vld_sr[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) rd_vld_sr[i] <= rd_vld_sr[i-1];

         if (ret) begin
            rd_sum     <= rd_sum_nxt;
            rd_ret_cnt <= rd_ret_cnt + CNT_ONE;
            if (last_ret) begin
               done  <= 1'b1;
               match <= (rd_sum_nxt == wr_sum);
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_stream_writer.sv
// Randomized bench for sram_stream_writer with a behavioural SRAM and a job-level reference model.
module tb_sram_stream_writer;
   localparam int NW = 4;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          verify_en = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [NW-1:0] in_mask = '0;
   logic          csb0, web0;
   logic [NW-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;
   logic          busy, done, match;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sram_stream_writer #(.NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
      .verify_en(verify_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mask(in_mask), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .dout0(dout0), .busy(busy), .done(done), .match(match)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM port 0: request sampled on the edge after it is registered, data valid one edge later.
   logic [DW-1:0] mem [0:1023];
   int rd_total = 0;
   int corrupt_at = -1;
   always @(posedge clk) begin
      if (csb0 === 1'b0) begin
         if (web0 === 1'b0) begin
            for (int b = 0; b < NW; b++)
               if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
         end else begin
            dout0    <= mem[addr0] ^ ((rd_total == corrupt_at) ? 32'h0000_0100 : 32'h0);
            rd_total <= rd_total + 1;
         end
      end
   end

   typedef struct {
      bit            wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NW-1:0] m;
      int            c;
   } op_t;
   op_t ops[$];

   always @(negedge clk) begin
      op_t o;
      if (csb0 === 1'b0) begin
         o.wr = (web0 === 1'b0);
         o.a  = addr0;
         o.d  = din0;
         o.m  = wmask0;
         o.c  = cyc;
         ops.push_back(o);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({csb0, web0} !== 2'b11 || wmask0 !== '0 || addr0 !== '0 || din0 !== '0) begin
         errors++;
         $display("FAIL reset_bus csb0=%b web0=%b wmask0=%h addr0=%h din0=%h required 1 1 0 0 0",
                  csb0, web0, wmask0, addr0, din0);
      end
      checks++;
      if ({in_ready, busy, done, match} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_status in_ready/busy/done/match=%b required 0000",
                  {in_ready, busy, done, match});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || csb0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release busy=%b csb0=%b required 0 1", busy, csb0);
      end
   endtask

   // Runs one job and checks the bus trace, timing and result against the job-level model.
   // vmode: 0 valid every cycle, 1 alternating 1,0,1..., 2 random.
   task automatic run_job(input string name, input int base, input int len, input bit ver,
                          input int vmode, input bit corrupt);
      int op0, beats, it, k, rdy_bad, last_w, done_cyc, nw, nr;
      logic [DW-1:0] ed[$];
      logic [NW-1:0] em[$];
      int ac[$];
      op_t wq[$], rq[$];
      logic [DW-1:0] sum_w, sum_r;
      bit v, exp_match;

      op0 = ops.size();
      corrupt_at = corrupt ? rd_total + 2 : -1;
      base_addr = AW'(base); length = (AW+1)'(len); verify_en = ver; start = 1'b1;
      @(negedge clk);
      start = 1'b0; base_addr = AW'($urandom); length = (AW+1)'($urandom); verify_en = 1'($urandom);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s_start busy=%b done=%b required 1 0", name, busy, done);
      end

      beats = 0; it = 0; rdy_bad = 0;
      while (beats < len && it < 4000) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (it % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         in_valid = v; in_data = $urandom; in_mask = NW'($urandom);
         if (in_ready !== 1'b1) rdy_bad++;
         if (v) begin
            ed.push_back(in_data);
            em.push_back(ver ? {NW{1'b1}} : in_mask);
            ac.push_back(cyc + 1);
            beats++;
         end
         it++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (rdy_bad != 0 || beats != len) begin
         errors++;
         $display("FAIL %s_stream in_ready low on %0d cycles, beats %0d required 0 and %0d",
                  name, rdy_bad, beats, len);
      end

      k = 0;
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      done_cyc = cyc;
      last_w = ac[len-1];
      checks++;
      if (done !== 1'b1 || done_cyc != last_w + (ver ? len + RL : 0)) begin
         errors++;
         $display("FAIL %s_done_time done=%b at cycle %0d required 1 at %0d",
                  name, done, done_cyc, last_w + (ver ? len + RL : 0));
      end

      sum_w = '0; sum_r = '0;
      for (int i = 0; i < len; i++) begin
         sum_w += ed[i];
         sum_r += (corrupt && i == 2) ? (ed[i] ^ 32'h0000_0100) : ed[i];
      end
      exp_match = ver ? (sum_w == sum_r) : 1'b1;
      checks++;
      if (match !== exp_match || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_result match=%b busy=%b in_ready=%b required %b 0 0",
                  name, match, busy, in_ready, exp_match);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (csb0 !== 1'b1) begin
         errors++;
         $display("FAIL %s_bus_idle csb0=%b required 1", name, csb0);
      end

      for (int i = op0; i < ops.size(); i++)
         if (ops[i].wr) wq.push_back(ops[i]); else rq.push_back(ops[i]);
      nw = wq.size(); nr = rq.size();
      checks++;
      if (nw != len || nr != (ver ? len : 0)) begin
         errors++;
         $display("FAIL %s_op_count writes=%0d reads=%0d required %0d %0d",
                  name, nw, nr, len, ver ? len : 0);
      end
      for (int i = 0; i < nw && i < len; i++) begin
         checks++;
         if (wq[i].a !== AW'((base + i) % 1024) || wq[i].d !== ed[i] ||
             wq[i].m !== em[i] || wq[i].c != ac[i]) begin
            errors++;
            $display("FAIL %s_write%0d addr=%0d data=%h mask=%h cyc=%0d required %0d %h %h %0d",
                     name, i, wq[i].a, wq[i].d, wq[i].m, wq[i].c,
                     (base + i) % 1024, ed[i], em[i], ac[i]);
         end
      end
      if (ver) begin
         for (int j = 0; j < nr && j < len; j++) begin
            checks++;
            if (rq[j].a !== AW'((base + j) % 1024) || rq[j].m !== '0 ||
                rq[j].c != last_w + 1 + j) begin
               errors++;
               $display("FAIL %s_read%0d addr=%0d mask=%h cyc=%0d required %0d 0 %0d",
                        name, j, rq[j].a, rq[j].m, rq[j].c, (base + j) % 1024, last_w + 1 + j);
            end
         end
         nw = 0;
         for (int i = 0; i < len; i++)
            if (mem[(base + i) % 1024] !== ed[i]) nw++;
         checks++;
         if (nw != 0) begin
            errors++;
            $display("FAIL %s_mem_content %0d words differ required 0", name, nw);
         end
      end
   endtask

   task automatic test_zero_len();
      int op0;
      base_addr = AW'(17); length = '0; verify_en = 1'b1; start = 1'b1;
      op0 = ops.size();
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({done, match, busy, csb0} !== 4'b1101) begin
         errors++;
         $display("FAIL zero_len done/match/busy/csb0=%b required 1101", {done, match, busy, csb0});
      end
      in_valid = 1'b1; in_data = $urandom;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ops.size() != op0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_idle ops=%0d in_ready=%b required 0 0", ops.size() - op0, in_ready);
      end
   endtask

   task automatic test_abort();
      int op0;
      op0 = ops.size();
      base_addr = AW'(100); length = 11'd8; verify_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      repeat (2) begin
         in_data = $urandom; in_mask = NW'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b1; base_addr = AW'(500); length = '0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL busy_start busy=%b done=%b required 1 0", busy, done);
      end
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ops.size() - op0 != 3 || ops[ops.size()-1].a !== AW'(102)) begin
         errors++;
         $display("FAIL busy_start_addr ops=%0d last_addr=%0d required 3 102",
                  ops.size() - op0, ops[ops.size()-1].a);
      end
      in_valid = 1'b1; rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({csb0, busy, done, in_ready} !== 4'b1000) begin
         errors++;
         $display("FAIL abort csb0/busy/done/in_ready=%b required 1000", {csb0, busy, done, in_ready});
      end
      in_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      run_job("t1_b2b", 0, 4, 1'b0, 0, 1'b0);
      run_job("t2_wrap", 1022, 4, 1'b1, 0, 1'b0);
      run_job("t3_gaps", 0, 3, 1'b0, 1, 1'b0);
      run_job("t5_corrupt", $urandom_range(0, 1023), 5, 1'b1, 2, 1'b1);
      test_zero_len();
      for (int n = 0; n < 6; n++)
         run_job("rand", $urandom_range(0, 1023), $urandom_range(1, 40), 1'($urandom), 2, 1'b0);
      run_job("full", $urandom_range(0, 1023), 1024, 1'b1, 0, 1'b0);
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
